// File: rtl/data_sram_if.sv
// Data-SRAM request/response bundle between a load/store unit and
// the late-write SRAM slave.
interface data_sram_if;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;
    logic        wbuf_valid;

    modport master (
        output data_sram_en,
        output data_sram_wen,
        output data_sram_addr,
        output data_sram_wdata,
        input  data_sram_rdata,
        input  wbuf_valid
    );

    modport slave (
        input  data_sram_en,
        input  data_sram_wen,
        input  data_sram_addr,
        input  data_sram_wdata,
        output data_sram_rdata,
        output wbuf_valid
    );
endinterface

// File: rtl/data_sram_slave.sv
// Single-port data SRAM with a one-entry late-write buffer.
// Stores are deferred and drained on non-load cycles; loads forward from the buffer.
module data_sram_slave #(
    parameter int          ADDR_WIDTH  = 10,
    parameter logic [31:0] RESET_RDATA = 32'h0
) (
    input  logic          clk,
    input  logic          reset,
    data_sram_if.slave    bus
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic {
        WB_EMPTY,
        WB_FULL
    } wb_state_e;

    logic [31:0] mem [DEPTH];

    wb_state_e             state_q, state_d;
    logic [ADDR_WIDTH-1:0] wb_idx_q, wb_idx_d;
    logic [3:0]            wb_wen_q, wb_wen_d;
    logic [31:0]           wb_wdata_q, wb_wdata_d;
    logic [31:0]           rd_raw_q, rd_raw_d;
    logic [31:0]           fwd_data_q, fwd_data_d;
    logic [3:0]            fwd_mask_q, fwd_mask_d;

    logic [ADDR_WIDTH-1:0] req_idx;
    logic                  is_load;
    logic                  is_store;
    logic                  drain;
    logic                  hit;
    logic                  unused_addr_bits;

    assign unused_addr_bits = ^{bus.data_sram_addr[31:ADDR_WIDTH+2],
                                bus.data_sram_addr[1:0]};

    always_comb begin
        req_idx  = bus.data_sram_addr[ADDR_WIDTH+1:2];
        is_load  = bus.data_sram_en && (bus.data_sram_wen == 4'b0);
        is_store = bus.data_sram_en && (bus.data_sram_wen != 4'b0);
        drain    = (state_q == WB_FULL) && !is_load;
        hit      = (state_q == WB_FULL) && (wb_idx_q == req_idx);
    end

    always_comb begin
        state_d    = state_q;
        wb_idx_d   = wb_idx_q;
        wb_wen_d   = wb_wen_q;
        wb_wdata_d = wb_wdata_q;
        if (is_store) begin
            state_d    = WB_FULL;
            wb_idx_d   = req_idx;
            wb_wen_d   = bus.data_sram_wen;
            wb_wdata_d = bus.data_sram_wdata;
        end else if (!bus.data_sram_en) begin
            state_d = WB_EMPTY;
        end
    end

    // Forward match and mask are frozen at the load; merge happens after the flops.
    always_comb begin
        rd_raw_d   = rd_raw_q;
        fwd_mask_d = fwd_mask_q;
        fwd_data_d = fwd_data_q;
        if (is_load) begin
            rd_raw_d   = mem[req_idx];
            fwd_mask_d = hit ? wb_wen_q : 4'b0;
            fwd_data_d = wb_wdata_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= WB_EMPTY;
            wb_idx_q   <= '0;
            wb_wen_q   <= '0;
            wb_wdata_q <= '0;
            rd_raw_q   <= RESET_RDATA;
            fwd_mask_q <= '0;
            fwd_data_q <= '0;
        end else begin
            state_q    <= state_d;
            wb_idx_q   <= wb_idx_d;
            wb_wen_q   <= wb_wen_d;
            wb_wdata_q <= wb_wdata_d;
            rd_raw_q   <= rd_raw_d;
            fwd_mask_q <= fwd_mask_d;
            fwd_data_q <= fwd_data_d;
        end
    end

    // Array is never reset; reset empties the buffer so nothing drains.
    always_ff @(posedge clk) begin
        if (drain) begin
            for (int i = 0; i < 4; i++) begin
                if (wb_wen_q[i]) begin
                    mem[wb_idx_q][8*i +: 8] <= wb_wdata_q[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        bus.data_sram_rdata = rd_raw_q;
        for (int i = 0; i < 4; i++) begin
            if (fwd_mask_q[i]) begin
                bus.data_sram_rdata[8*i +: 8] = fwd_data_q[8*i +: 8];
            end
        end
    end

    assign bus.wbuf_valid = (state_q == WB_FULL);

endmodule

// File: tb/tb_data_sram_slave.sv
// Directed bench for data_sram_slave: late-write buffer, drain,
// forwarding, aliasing and asynchronous reset behaviour.
module tb_data_sram_slave;

    localparam logic [31:0] RST_VAL = 32'h0BAD_F00D;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    data_sram_if bus ();

    data_sram_slave #(
        .ADDR_WIDTH  (10),
        .RESET_RDATA (RST_VAL)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one request, clock it, and settle 1 time unit past the edge.
    task automatic cyc(input logic en, input logic [3:0] wen,
                       input logic [31:0] addr, input logic [31:0] wdata);
        bus.data_sram_en    = en;
        bus.data_sram_wen   = wen;
        bus.data_sram_addr  = addr;
        bus.data_sram_wdata = wdata;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.data_sram_en    = 1'b0;
        bus.data_sram_wen   = 4'h0;
        bus.data_sram_addr  = 32'h0;
        bus.data_sram_wdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (bus.wbuf_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_wbuf got=%b want=0", bus.wbuf_valid);
        end
        total++;
        if (bus.data_sram_rdata !== RST_VAL) begin
            bad++;
            $display("FAIL reset_rdata got=%h want=%h", bus.data_sram_rdata, RST_VAL);
        end
        reset = 1'b0;
    endtask

    task automatic test_store_drain();
        cyc(1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF);
        total++;
        if (bus.wbuf_valid !== 1'b1) begin
            bad++;
            $display("FAIL sd_wbuf_set got=%b want=1", bus.wbuf_valid);
        end
        total++;
        if (bus.data_sram_rdata !== RST_VAL) begin
            bad++;
            $display("FAIL sd_store_hold got=%h want=%h", bus.data_sram_rdata, RST_VAL);
        end
        idle();
        total++;
        if (bus.wbuf_valid !== 1'b0) begin
            bad++;
            $display("FAIL sd_wbuf_clr got=%b want=0", bus.wbuf_valid);
        end
        total++;
        if (bus.data_sram_rdata !== RST_VAL) begin
            bad++;
            $display("FAIL sd_idle_hold got=%h want=%h", bus.data_sram_rdata, RST_VAL);
        end
        cyc(1'b1, 4'h0, 32'h10, 32'h0);
        total++;
        if (bus.data_sram_rdata !== 32'hDEAD_BEEF) begin
            bad++;
            $display("FAIL sd_load got=%h want=deadbeef", bus.data_sram_rdata);
        end
        idle();
        idle();
        total++;
        if (bus.data_sram_rdata !== 32'hDEAD_BEEF) begin
            bad++;
            $display("FAIL sd_hold got=%h want=deadbeef", bus.data_sram_rdata);
        end
    endtask

    task automatic test_forward();
        cyc(1'b1, 4'hF, 32'h20, 32'h1122_3344);
        idle();
        cyc(1'b1, 4'b0010, 32'h20, 32'h0000_AA00);
        cyc(1'b1, 4'h0, 32'h20, 32'h0);
        total++;
        if (bus.data_sram_rdata !== 32'h1122_AA44) begin
            bad++;
            $display("FAIL fwd_merge got=%h want=1122aa44", bus.data_sram_rdata);
        end
        total++;
        if (bus.wbuf_valid !== 1'b1) begin
            bad++;
            $display("FAIL fwd_wbuf got=%b want=1", bus.wbuf_valid);
        end
        idle();
        total++;
        if (bus.data_sram_rdata !== 32'h1122_AA44) begin
            bad++;
            $display("FAIL fwd_hold got=%h want=1122aa44", bus.data_sram_rdata);
        end
        cyc(1'b1, 4'h0, 32'h20, 32'h0);
        total++;
        if (bus.data_sram_rdata !== 32'h1122_AA44) begin
            bad++;
            $display("FAIL fwd_partial_drain got=%h want=1122aa44", bus.data_sram_rdata);
        end
        cyc(1'b1, 4'b1001, 32'h20, 32'hEE00_00FF);
        cyc(1'b1, 4'h0, 32'h20, 32'h0);
        total++;
        if (bus.data_sram_rdata !== 32'hEE22_AAFF) begin
            bad++;
            $display("FAIL fwd_mask2 got=%h want=ee22aaff", bus.data_sram_rdata);
        end
        idle();
    endtask

    task automatic test_load_hold();
        logic [31:0] a;
        logic [31:0] exp;
        cyc(1'b1, 4'hF, 32'h34, 32'h1234_5678);
        idle();
        cyc(1'b1, 4'hF, 32'h30, 32'hA5A5_A5A5);
        for (int i = 0; i < 8; i++) begin
            a   = i[0] ? 32'h30 : 32'h34;
            exp = i[0] ? 32'hA5A5_A5A5 : 32'h1234_5678;
            cyc(1'b1, 4'h0, a, 32'h0);
            total++;
            if (bus.wbuf_valid !== 1'b1) begin
                bad++;
                $display("FAIL lh_wbuf[%0d] got=%b want=1", i, bus.wbuf_valid);
            end
            total++;
            if (bus.data_sram_rdata !== exp) begin
                bad++;
                $display("FAIL lh_rdata[%0d] got=%h want=%h", i, bus.data_sram_rdata, exp);
            end
        end
        idle();
        cyc(1'b1, 4'h0, 32'h30, 32'h0);
        total++;
        if (bus.data_sram_rdata !== 32'hA5A5_A5A5) begin
            bad++;
            $display("FAIL lh_drained got=%h want=a5a5a5a5", bus.data_sram_rdata);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] v;
        for (int i = 0; i < 3; i++) begin
            v = 32'(i + 1);
            cyc(1'b1, 4'hF, 32'h40 + 32'(4 * i), v);
            total++;
            if (bus.wbuf_valid !== 1'b1) begin
                bad++;
                $display("FAIL b2b_wbuf[%0d] got=%b want=1", i, bus.wbuf_valid);
            end
        end
        idle();
        total++;
        if (bus.wbuf_valid !== 1'b0) begin
            bad++;
            $display("FAIL b2b_wbuf_clr got=%b want=0", bus.wbuf_valid);
        end
        for (int i = 0; i < 3; i++) begin
            v = 32'(i + 1);
            cyc(1'b1, 4'h0, 32'h40 + 32'(4 * i), 32'h0);
            total++;
            if (bus.data_sram_rdata !== v) begin
                bad++;
                $display("FAIL b2b_load[%0d] got=%h want=%h", i, bus.data_sram_rdata, v);
            end
        end
    endtask

    task automatic test_alias();
        cyc(1'b1, 4'hF, 32'h0000_1004, 32'h5);
        idle();
        cyc(1'b1, 4'h0, 32'h0000_0004, 32'h0);
        total++;
        if (bus.data_sram_rdata !== 32'h5) begin
            bad++;
            $display("FAIL alias_low got=%h want=5", bus.data_sram_rdata);
        end
        cyc(1'b1, 4'h0, 32'hFFFF_F006, 32'h0);
        total++;
        if (bus.data_sram_rdata !== 32'h5) begin
            bad++;
            $display("FAIL alias_high got=%h want=5", bus.data_sram_rdata);
        end
    endtask

    task automatic test_reset_discard();
        cyc(1'b1, 4'hF, 32'h50, 32'h1111_1111);
        idle();
        cyc(1'b1, 4'hF, 32'h50, 32'h77);
        #2;
        reset = 1'b1;
        #1;
        total++;
        if (bus.wbuf_valid !== 1'b0) begin
            bad++;
            $display("FAIL rd_wbuf_async got=%b want=0", bus.wbuf_valid);
        end
        total++;
        if (bus.data_sram_rdata !== RST_VAL) begin
            bad++;
            $display("FAIL rd_rdata_async got=%h want=%h", bus.data_sram_rdata, RST_VAL);
        end
        cyc(1'b1, 4'hF, 32'h50, 32'h99);
        total++;
        if (bus.wbuf_valid !== 1'b0) begin
            bad++;
            $display("FAIL rd_ignore got=%b want=0", bus.wbuf_valid);
        end
        reset = 1'b0;
        cyc(1'b1, 4'h0, 32'h50, 32'h0);
        total++;
        if (bus.data_sram_rdata !== 32'h1111_1111) begin
            bad++;
            $display("FAIL rd_first_load got=%h want=11111111", bus.data_sram_rdata);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_store_drain();
        test_forward();
        test_load_hold();
        test_back_to_back();
        test_alias();
        test_reset_discard();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_sram_slave.md
DATA_SRAM_SLAVE -- requirements
Module: data_sram_slave

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, word-index width (array depth 2^ADDR_WIDTH 32-bit words, 4 KB).
REQ-002 SHALL have parameter RESET_RDATA, default 32'h0, value of data_sram_rdata after reset.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port data_sram_en  input  1  request valid this cycle.
REQ-006 SHALL have port data_sram_wen  input  4  byte write enables; any bit set = store, all zero = load.
REQ-007 SHALL have port data_sram_addr  input  32  byte address; word index = addr[ADDR_WIDTH+1:2], other bits ignored.
REQ-008 SHALL have port data_sram_wdata  input  32  store data, byte lane i valid where wen[i]=1.
REQ-009 SHALL have port data_sram_rdata  output  32  load data, registered.
REQ-010 SHALL have port wbuf_valid  output  1  late-write buffer holds an undrained store.

Function
REQ-011 SHALL accept one request per cycle with no backpressure; no stall signal exists.
REQ-012 Load (en=1, wen=0) SHALL read the array in cycle N; data_sram_rdata SHALL present the result from cycle N+1 and hold it until the next load completes.
REQ-013 Cycles with en=0 or a store SHALL NOT change data_sram_rdata.
REQ-014 Store (en=1, wen!=0) SHALL NOT write the array in its own cycle; it SHALL be captured in a single-entry late-write buffer (index, wen, wdata).
REQ-015 Buffer drain: on any cycle that is not a load (en=0, or a store) with wbuf_valid=1, the buffered entry SHALL be written to the array, byte lanes per buffered wen only.
REQ-016 Store with wbuf_valid=1: SHALL drain old entry and capture new entry in the same cycle; wbuf_valid stays 1; no overflow possible.
REQ-017 Load cycles SHALL NOT drain; buffer holds indefinitely across consecutive loads.
REQ-018 Two-state control per buffer: EMPTY -> FULL on store; FULL -> FULL on store; FULL -> EMPTY on en=0; FULL -> FULL on load.
REQ-019 Forwarding: load whose index equals buffered index with wbuf_valid=1 SHALL return, per byte lane, buffered wdata where buffered wen=1, else array data.
REQ-020 Forwarding SHALL apply match/mask captured in the load cycle; merge SHALL occur on the registered output path so rdata timing is unchanged.
REQ-021 Non-matching load SHALL return array contents unaffected by the pending entry.
REQ-022 Store with wen=0 is impossible by definition; store with partial wen SHALL leave unselected array bytes unchanged after drain.
REQ-023 Index wrap: addresses differing only above bit ADDR_WIDTH+1 SHALL alias the same word.
REQ-024 Array contents SHALL NOT be reset; uninitialised reads are don't-care.
REQ-025 wbuf_valid SHALL equal buffer state register directly (no combinational path from inputs).

Reset
REQ-026 Assertion of reset SHALL immediately clear wbuf_valid to 0 and set data_sram_rdata to RESET_RDATA, independent of clk.
REQ-027 Store pending in the buffer when reset asserts SHALL be discarded (array not written); requests during reset SHALL be ignored.
REQ-028 First request SHALL be honoured on the first rising edge after reset deasserts.

Verification
REQ-029 Store addr 0x10 wen 4'hF wdata 0xDEADBEEF, then en=0, then load 0x10 -> wbuf_valid 1 then 0; rdata = 0xDEADBEEF one cycle after load.
REQ-030 Word 0x20 = 0x11223344; store 0x20 wen 4'b0010 wdata 0x0000AA00, immediately load 0x20 -> rdata 0x1122AA44 (forwarded), wbuf_valid still 1.
REQ-031 Store 0x30 0xA5A5A5A5 then 8 consecutive loads of 0x34 -> wbuf_valid stays 1 all 8 cycles; loads of 0x30 in that window return 0xA5A5A5A5.
REQ-032 Back-to-back stores 0x40=1, 0x44=2, 0x48=3 then en=0, loads of each -> 1, 2, 3; wbuf_valid never deasserts until the en=0 cycle.
REQ-033 ADDR_WIDTH=10: store 0x00001004 = 0x5, drain, load 0x00000004 -> rdata 0x5 (alias).
REQ-034 Store 0x50 = 0x77 then assert reset mid-cycle before any drain, release, load 0x50 -> wbuf_valid 0 immediately at reset; rdata != 0x77 forwarded (array prior value returned).
